// File: rtl/olivia_retire_trace.sv
// olivia_retire_trace
// Retire-trace recorder for the Olivia LEGv8 core. Each retired instruction
// is captured as {PC, instruction, result, class} into a circular buffer.
// A PC match or an unknown opcode triggers a short post-trigger window, after
// which the buffer freezes until re-armed. Entries are read back oldest-first
// through a registered port.
//
// Optional feature macro: TRACE_CLASS_CNT_EN
//   defined   -> sixteen per-class retire counters, selected by cnt_sel
//   undefined -> no counters, cnt_val tied to zero
//
// state | meaning
// ------+---------------------------------------------------------------
// ARMED | recording, watching for a trigger
// POST  | trigger seen, recording the post-trigger window
// FROZEN| window closed, retires dropped, buffer held until arm/rst

module olivia_retire_trace #(
    parameter int PC_W     = 64,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ret_valid,
    input  logic [PC_W-1:0]            ret_pc,
    input  logic [31:0]                ret_instr,
    input  logic [DATA_W-1:0]          ret_result,
    input  logic                       arm,
    input  logic                       trig_pc_en,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_valid,
    output logic                       rd_hit,
    output logic [PC_W-1:0]            rd_pc,
    output logic [31:0]                rd_instr,
    output logic [DATA_W-1:0]          rd_result,
    output logic [3:0]                 rd_class,
    output logic [$clog2(DEPTH):0]     entry_cnt,
    output logic [1:0]                 state,
    output logic                       unk_seen,
    input  logic [3:0]                 cnt_sel,
    output logic [CNT_W-1:0]           cnt_val
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_CNT);

    localparam logic [3:0] CLS_NOP  = 4'd0;
    localparam logic [3:0] CLS_ADD  = 4'd1;
    localparam logic [3:0] CLS_SUB  = 4'd2;
    localparam logic [3:0] CLS_AND  = 4'd3;
    localparam logic [3:0] CLS_ORR  = 4'd4;
    localparam logic [3:0] CLS_LDUR = 4'd5;
    localparam logic [3:0] CLS_STUR = 4'd6;
    localparam logic [3:0] CLS_CBZ  = 4'd7;
    localparam logic [3:0] CLS_B    = 4'd8;
    localparam logic [3:0] CLS_UNK  = 4'd15;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_POST   = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   post_q, post_d;
    logic [AW-1:0]   wptr;
    logic [CW-1:0]   cnt_q;
    logic            unk_q;

    logic [PC_W-1:0]   mem_pc     [DEPTH];
    logic [31:0]       mem_instr  [DEPTH];
    logic [DATA_W-1:0] mem_result [DEPTH];
    logic [3:0]        mem_class  [DEPTH];

    logic [3:0]      ret_class;
    logic            rec;
    logic            trig;
    logic [AW-1:0]   rd_slot;
    logic            rd_in_range;

    // Decode the retiring instruction into its class code, first match wins
    always_comb begin
        ret_class = CLS_UNK;
        if (ret_instr == 32'h0) begin
            ret_class = CLS_NOP;
        end else if (ret_instr[31:24] == 8'hB4) begin
            ret_class = CLS_CBZ;
        end else if (ret_instr[31:26] == 6'b000101) begin
            ret_class = CLS_B;
        end else begin
            case (ret_instr[31:21])
                11'b10001011000: ret_class = CLS_ADD;
                11'b11001011000: ret_class = CLS_SUB;
                11'b10001010000: ret_class = CLS_AND;
                11'b10101010000: ret_class = CLS_ORR;
                11'b11111000010: ret_class = CLS_LDUR;
                11'b11111000000: ret_class = CLS_STUR;
                default:         ret_class = CLS_UNK;
            endcase
        end
    end

    // arm wins over a same-cycle retire, so the retire is simply not recorded
    assign rec  = ret_valid && (state_q != ST_FROZEN) && !arm;
    assign trig = rec && (state_q == ST_ARMED) &&
                  ((trig_pc_en && (ret_pc == trig_pc)) || (ret_class == CLS_UNK));

    // Next-state and post-window counter
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        if (arm) begin
            state_d = ST_ARMED;
            post_d  = '0;
        end else if (rec) begin
            case (state_q)
                ST_ARMED: begin
                    if (trig) begin
                        if (POST_CNT == 0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d = ST_POST;
                            post_d  = POST_LOAD;
                        end
                    end
                end
                ST_POST: begin
                    post_d = post_q - AW'(1);
                    if (post_q == AW'(1)) begin
                        state_d = ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARMED;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    // Write pointer and saturating fill count
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            wptr  <= '0;
            cnt_q <= '0;
        end else if (rec) begin
            wptr <= wptr + AW'(1);
            if (cnt_q != FULL_CNT) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Trace storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (rec) begin
            mem_pc[wptr]     <= ret_pc;
            mem_instr[wptr]  <= ret_instr;
            mem_result[wptr] <= ret_result;
            mem_class[wptr]  <= ret_class;
        end
    end

    // Sticky flag for any recorded unknown opcode
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            unk_q <= 1'b0;
        end else if (rec && (ret_class == CLS_UNK)) begin
            unk_q <= 1'b1;
        end
    end

    // Oldest entry sits entry_cnt slots behind the write pointer; when full the
    // low bits of the count are zero and the oldest is at wptr itself
    assign rd_slot     = wptr - cnt_q[AW-1:0] + rd_idx;
    assign rd_in_range = ({1'b0, rd_idx} < cnt_q);

    // Registered read port; uses pre-write pointers and contents
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_pc     <= '0;
            rd_instr  <= '0;
            rd_result <= '0;
            rd_class  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_hit   <= rd_en && rd_in_range;
            if (rd_en && rd_in_range) begin
                rd_pc     <= mem_pc[rd_slot];
                rd_instr  <= mem_instr[rd_slot];
                rd_result <= mem_result[rd_slot];
                rd_class  <= mem_class[rd_slot];
            end else begin
                rd_pc     <= '0;
                rd_instr  <= '0;
                rd_result <= '0;
                rd_class  <= '0;
            end
        end
    end

    assign entry_cnt = cnt_q;
    assign state     = state_q;
    assign unk_seen  = unk_q;

`ifdef TRACE_CLASS_CNT_EN
    logic [CNT_W-1:0] cls_cnt [16];

    // Per-class retire counters, free-running wrap
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            for (int i = 0; i < 16; i++) begin
                cls_cnt[i] <= '0;
            end
        end else if (rec) begin
            cls_cnt[ret_class] <= cls_cnt[ret_class] + CNT_W'(1);
        end
    end

    assign cnt_val = cls_cnt[cnt_sel];
`else
    logic cnt_sel_unused;
    assign cnt_sel_unused = ^cnt_sel;
    assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_olivia_retire_trace.sv
// Directed bench for olivia_retire_trace with DEPTH=8, POST_CNT=2.
// Inputs change on the falling edge, outputs are checked on the next falling edge.

module tb_olivia_retire_trace;

    localparam int PC_W   = 64;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int POST   = 2;
    localparam int CNT_W  = 16;

    localparam logic [31:0] I_ADD = 32'h8B020020;
    localparam logic [31:0] I_SUB = 32'hCB020020;
    localparam logic [31:0] I_LDR = 32'hF8400020;
    localparam logic [31:0] I_CBZ = 32'hB4000040;
    localparam logic [31:0] I_B   = 32'h14000001;
    localparam logic [31:0] I_UNK = 32'hFFFFFFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              ret_valid;
    logic [PC_W-1:0]   ret_pc;
    logic [31:0]       ret_instr;
    logic [DATA_W-1:0] ret_result;
    logic              arm;
    logic              trig_pc_en;
    logic [PC_W-1:0]   trig_pc;
    logic              rd_en;
    logic [2:0]        rd_idx;
    logic              rd_valid;
    logic              rd_hit;
    logic [PC_W-1:0]   rd_pc;
    logic [31:0]       rd_instr;
    logic [DATA_W-1:0] rd_result;
    logic [3:0]        rd_class;
    logic [3:0]        entry_cnt;
    logic [1:0]        state;
    logic              unk_seen;
    logic [3:0]        cnt_sel;
    logic [CNT_W-1:0]  cnt_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    olivia_retire_trace #(
        .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST_CNT(POST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_result(ret_result),
        .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_result(rd_result), .rd_class(rd_class),
        .entry_cnt(entry_cnt), .state(state), .unk_seen(unk_seen),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [63:0] pc, input logic [31:0] instr);
        ret_valid  = 1'b1;
        ret_pc     = pc;
        ret_instr  = instr;
        ret_result = pc + 64'd100;
        @(negedge clk);
        ret_valid  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(negedge clk);
        rd_en  = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_result = '0;
        arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; rd_en = 1'b0; rd_idx = '0; cnt_sel = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_cnt", entry_cnt, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_unk", unk_seen, 0);
        chk("rst_cnt_val", cnt_val, 0);
        rst = 1'b0;

        // three ADD retires
        retire(64'd0, I_ADD);
        retire(64'd4, I_ADD);
        retire(64'd8, I_ADD);
        chk("fill3_cnt", entry_cnt, 3);
        rd(3'd0);
        chk("r0_valid", rd_valid, 1);
        chk("r0_hit", rd_hit, 1);
        chk("r0_pc", rd_pc, 0);
        chk("r0_class", rd_class, 1);
        chk("r0_instr", rd_instr, I_ADD);
        chk("r0_result", rd_result, 100);
        @(negedge clk);
        chk("r0_valid_drop", rd_valid, 0);
        rd(3'd7);
        chk("r7_miss_valid", rd_valid, 1);
        chk("r7_miss_hit", rd_hit, 0);
        chk("r7_miss_pc", rd_pc, 0);
        chk("r7_miss_class", rd_class, 0);
        chk("r7_miss_result", rd_result, 0);

        // wrap: ten retires into eight slots
        do_arm();
        chk("arm_cnt", entry_cnt, 0);
        for (int i = 0; i < 10; i++) retire(64'(4 * i), I_ADD);
        chk("wrap_cnt", entry_cnt, 8);
        chk("wrap_state", state, 0);
        rd(3'd0);
        chk("wrap_r0_pc", rd_pc, 8);
        rd(3'd7);
        chk("wrap_r7_pc", rd_pc, 36);
        rd(3'd3);
        chk("wrap_r3_pc", rd_pc, 20);
        // read and record together: read sees pre-write buffer
        rd_en = 1'b1; rd_idx = 3'd0;
        retire(64'd40, I_ADD);
        rd_en = 1'b0;
        chk("rdwr_pc", rd_pc, 8);
        rd(3'd0);
        chk("rdwr_after_pc", rd_pc, 12);
        rd(3'd7);
        chk("rdwr_newest_pc", rd_pc, 40);

        // PC-match trigger at 16, two post entries, then frozen
        do_arm();
        trig_pc_en = 1'b1; trig_pc = 64'd16;
        for (int i = 0; i < 4; i++) retire(64'(4 * i), I_ADD);
        chk("pre_trig_state", state, 0);
        retire(64'd16, I_ADD);
        chk("trig_state", state, 1);
        retire(64'd20, I_ADD);
        chk("post1_state", state, 1);
        retire(64'd24, I_ADD);
        chk("post2_state", state, 2);
        for (int i = 7; i <= 10; i++) retire(64'(4 * i), I_ADD);
        chk("frozen_cnt", entry_cnt, 7);
        chk("frozen_state", state, 2);
        rd(3'd6);
        chk("frozen_newest_pc", rd_pc, 24);
        rd(3'd0);
        chk("frozen_oldest_pc", rd_pc, 0);
        chk("frozen_unk", unk_seen, 0);

        // arm with simultaneous retire: retire dropped
        arm = 1'b1;
        retire(64'h100, I_ADD);
        arm = 1'b0;
        chk("arm_ret_cnt", entry_cnt, 0);
        chk("arm_ret_state", state, 0);
        rd(3'd0);
        chk("arm_ret_hit", rd_hit, 0);
        trig_pc_en = 1'b0;

        // unknown opcode triggers
        retire(64'h200, I_UNK);
        chk("unk_state", state, 1);
        chk("unk_seen", unk_seen, 1);
        chk("unk_cnt", entry_cnt, 1);
        rd(3'd0);
        chk("unk_class", rd_class, 15);
        chk("unk_pc", rd_pc, 64'h200);

        // reset mid-POST and mid-read
        retire(64'h204, I_ADD);
        chk("mid_post_state", state, 1);
        rst = 1'b1; rd_en = 1'b1; rd_idx = 3'd0;
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0;
        chk("rst_post_state", state, 0);
        chk("rst_post_cnt", entry_cnt, 0);
        chk("rst_post_unk", unk_seen, 0);
        chk("rst_post_rd_valid", rd_valid, 0);

        // class decode and per-class counts
        retire(64'd0, I_ADD);
        retire(64'd4, I_ADD);
        retire(64'd8, I_ADD);
        retire(64'd12, I_CBZ);
        retire(64'd16, I_B);
        retire(64'd20, I_SUB);
        retire(64'd24, I_LDR);
        retire(64'd28, 32'h0);
        chk("cls_cnt", entry_cnt, 8);
        chk("cls_state", state, 0);
        rd(3'd3);
        chk("cls_cbz", rd_class, 7);
        rd(3'd4);
        chk("cls_b", rd_class, 8);
        rd(3'd5);
        chk("cls_sub", rd_class, 2);
        rd(3'd6);
        chk("cls_ldur", rd_class, 5);
        rd(3'd7);
        chk("cls_nop", rd_class, 0);
        cnt_sel = 4'd1;
        #1;
`ifdef TRACE_CLASS_CNT_EN
        chk("cnt_add", cnt_val, 3);
`else
        chk("cnt_add", cnt_val, 0);
`endif
        cnt_sel = 4'd7;
        #1;
`ifdef TRACE_CLASS_CNT_EN
        chk("cnt_cbz", cnt_val, 1);
`else
        chk("cnt_cbz", cnt_val, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
